trap_sequencer: RTL
===================

// Module: trap_sequencer
// PURPOSE
//  Multi-cycle trap-entry/MRET sequencer, directly downstream of exception_handler.
//  Consumes exception_valid/exception_info/trap_vector; flushes and drains the pipeline.
//  Then issues one atomic CSR trap write (mepc/mcause/mtval/mstatus) and a PC redirect to fetch.
//  Also sequences MRET return (mstatus restore + redirect to mepc).
// PARAMETERS
//  DRAIN_TIMEOUT  16  max cycles in DRAIN waiting for pipe_drained_i before forced advance
//  CNT_WIDTH      32  width of trap counter (TRAP_SEQ_CNT_EN only)
// PORTS
//  clk_i              in   1        core clock
//  rst_ni             in   1        async active-low reset
//  exception_valid_i  in   1        exception/interrupt selected (from exception_handler)
//  exception_info_i   in   exception_info_t  selected exception record
//  trap_vector_i      in   addr_t   computed trap target
//  irq_pc_i           in   addr_t   PC of oldest unretired instr (mepc source for interrupts)
//  mret_i             in   1        MRET retiring in writeback (1-cycle pulse)
//  mepc_i             in   addr_t   current mepc CSR value
//  pipe_drained_i     in   1        no outstanding memory transactions
//  redirect_ready_i   in   1        fetch accepts PC redirect
//  flush_o            out  1        pipeline flush pulse
//  stall_fetch_o      out  1        hold fetch while sequencing
//  busy_o             out  1        sequencer not IDLE
//  csr_trap_we_o      out  1        commit trap CSR update (1 cycle)
//  csr_mepc_o         out  addr_t   value for mepc
//  csr_mcause_o       out  32       value for mcause
//  csr_mtval_o        out  32       value for mtval
//  csr_mret_we_o      out  1        commit MRET mstatus restore (1 cycle)
//  pc_redirect_valid_o out 1        redirect request
//  pc_redirect_o      out  addr_t   redirect target
//  trap_count_o       out  CNT_WIDTH traps taken (TRAP_SEQ_CNT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and latched registers 0.
//  IDLE: exception_valid_i -> latch info, vector; mepc=(exc_type==EXC_TYPE_INTERRUPT)?irq_pc_i:info.pc;
//   mcause={is_interrupt, cause zero-extended to 31b}; mtval=info.tval (0 for interrupts);
//   flush_o=1 that same cycle (combinational); next DRAIN.
//   mret_i alone -> latch mepc_i as target, flush_o=1; next MRET.
//   exception_valid_i && mret_i same cycle: exception wins, MRET dropped.
//  DRAIN: stall_fetch_o=1; drain counter counts up from 0; advance to CSR_WR when
//   pipe_drained_i=1 or counter==DRAIN_TIMEOUT-1; counter cleared on exit.
//  CSR_WR: csr_trap_we_o=1 exactly one cycle with latched values; next REDIRECT.
//  MRET: csr_mret_we_o=1 exactly one cycle; next REDIRECT.
//  REDIRECT: pc_redirect_valid_o=1, pc_redirect_o=latched target; hold stable until
//   redirect_ready_i; handshake cycle -> IDLE. Ready with valid low has no effect.
//  stall_fetch_o=1 and busy_o=1 in every non-IDLE state.
//  exception_valid_i/mret_i outside IDLE: ignored; no queueing.
//  Minimum trap latency: accept->redirect_valid = 3 cycles (IDLE,DRAIN,CSR_WR).
//  Reset mid-sequence: immediate return to IDLE; partial CSR writes never issued.
// CONFIGURATION
//  TRAP_SEQ_CNT_EN defined: trap_count_o increments by 1 on each CSR_WR cycle; wraps at 2^CNT_WIDTH.
//  Undefined: trap_count_o tied to '0; counter not instantiated.
// STRUCTURE
//  riscv_core_pkg: trap_seq_state_e {IDLE,DRAIN,CSR_WR,MRET,REDIRECT}; reuse exception_info_t,
//   addr_t, EXC_TYPE_INTERRUPT. Single module; no sub-module (drain timer inline).
// TESTING
//  1 exc cause=2, pc=0x100, tval=0xDEAD, vec=0x8000, drained=1, ready=1 -> flush@T0,
//   csr_trap_we@T2 mepc=0x100 mcause=0x2 mtval=0xDEAD, redirect 0x8000@T3, IDLE@T4.
//  2 timer irq, irq_pc_i=0x240, drained held 0 -> DRAIN lasts 16 cycles, then
//   mcause=0x80000007, mepc=0x240.
//  3 mret_i with mepc_i=0x300 -> csr_mret_we 1 cycle, redirect 0x300; csr_trap_we never set.
//  4 exception_valid_i and mret_i same cycle -> trap path only; csr_mret_we stays 0.
//  5 redirect_ready_i low 5 cycles -> pc_redirect_valid_o/pc_redirect_o stable; new
//   exception_valid_i during REDIRECT ignored.
//  6 rst_ni low in CSR_WR -> all outputs 0 asynchronously; with TRAP_SEQ_CNT_EN count=0.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// Shared types for the trap-entry / MRET sequencer slice.
// Optional trap counter is enabled by defining TRAP_SEQ_CNT_EN.
package trap_sequencer_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    EXC_TYPE_NONE      = 2'd0,
    EXC_TYPE_EXCEPTION = 2'd1,
    EXC_TYPE_INTERRUPT = 2'd2
  } exc_type_e;

  typedef struct packed {
    exc_type_e   exc_type;
    logic [4:0]  cause;
    addr_t       pc;
    logic [31:0] tval;
  } exception_info_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    CSR_WR   = 3'd2,
    MRET     = 3'd3,
    REDIRECT = 3'd4
  } trap_seq_state_e;

  // mcause: interrupt flag in bit 31, cause code zero-extended below it.
  function automatic logic [31:0] trap_mcause(input exception_info_t info);
    return {(info.exc_type == EXC_TYPE_INTERRUPT), 26'd0, info.cause};
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR/fetch-side signal bundle of trap_sequencer (TRAP_SEQ_CNT_EN gates trap_count_o).
interface trap_sequencer_if
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) ();

  logic                 exception_valid_i;
  exception_info_t      exception_info_i;
  addr_t                trap_vector_i;
  addr_t                irq_pc_i;
  logic                 mret_i;
  addr_t                mepc_i;
  logic                 pipe_drained_i;
  logic                 redirect_ready_i;

  logic                 flush_o;
  logic                 stall_fetch_o;
  logic                 busy_o;
  logic                 csr_trap_we_o;
  addr_t                csr_mepc_o;
  logic [31:0]          csr_mcause_o;
  logic [31:0]          csr_mtval_o;
  logic                 csr_mret_we_o;
  logic                 pc_redirect_valid_o;
  addr_t                pc_redirect_o;
  logic [CNT_WIDTH-1:0] trap_count_o;

  modport master (
    output exception_valid_i, exception_info_i, trap_vector_i, irq_pc_i,
           mret_i, mepc_i, pipe_drained_i, redirect_ready_i,
    input  flush_o, stall_fetch_o, busy_o, csr_trap_we_o, csr_mepc_o,
           csr_mcause_o, csr_mtval_o, csr_mret_we_o, pc_redirect_valid_o,
           pc_redirect_o, trap_count_o
  );

  modport slave (
    input  exception_valid_i, exception_info_i, trap_vector_i, irq_pc_i,
           mret_i, mepc_i, pipe_drained_i, redirect_ready_i,
    output flush_o, stall_fetch_o, busy_o, csr_trap_we_o, csr_mepc_o,
           csr_mcause_o, csr_mtval_o, csr_mret_we_o, pc_redirect_valid_o,
           pc_redirect_o, trap_count_o
  );

endinterface

// File: rtl/trap_sequencer.sv
// Trap-entry / MRET sequencer: flush, drain, atomic CSR write, PC redirect.
// Define TRAP_SEQ_CNT_EN to build the wrapping trap counter on trap_count_o.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input logic            clk_i,
  input logic            rst_ni,
  trap_sequencer_if.slave bus
);

  localparam int unsigned    DW         = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  trap_seq_state_e state_q, state_d;
  logic [DW-1:0]   drain_cnt_q;
  addr_t           mepc_q, target_q;
  logic [31:0]     mcause_q, mtval_q;
  logic            is_idle, exc_take, mret_take, drain_done, is_irq;

  assign is_idle    = (state_q == IDLE);
  // Exception has priority over a same-cycle MRET; the MRET is dropped.
  assign exc_take   = is_idle && bus.exception_valid_i;
  assign mret_take  = is_idle && bus.mret_i && !bus.exception_valid_i;
  assign drain_done = bus.pipe_drained_i || (drain_cnt_q == DRAIN_LAST);
  assign is_irq     = (bus.exception_info_i.exc_type == EXC_TYPE_INTERRUPT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (exc_take)       state_d = DRAIN;
        else if (mret_take) state_d = MRET;
      end
      DRAIN:    if (drain_done) state_d = CSR_WR;
      CSR_WR:   state_d = REDIRECT;
      MRET:     state_d = REDIRECT;
      REDIRECT: if (bus.redirect_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      target_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == DRAIN) && !drain_done) drain_cnt_q <= drain_cnt_q + DW'(1);
      else                                   drain_cnt_q <= '0;
      if (exc_take) begin
        mepc_q   <= is_irq ? bus.irq_pc_i : bus.exception_info_i.pc;
        mcause_q <= trap_mcause(bus.exception_info_i);
        mtval_q  <= is_irq ? '0 : bus.exception_info_i.tval;
        target_q <= bus.trap_vector_i;
      end else if (mret_take) begin
        target_q <= bus.mepc_i;
      end
    end
  end

  // Flush is combinational in the accept cycle; gated so reset forces it low.
  assign bus.flush_o             = rst_ni && is_idle && (bus.exception_valid_i || bus.mret_i);
  assign bus.stall_fetch_o       = !is_idle;
  assign bus.busy_o              = !is_idle;
  assign bus.csr_trap_we_o       = (state_q == CSR_WR);
  assign bus.csr_mret_we_o       = (state_q == MRET);
  assign bus.pc_redirect_valid_o = (state_q == REDIRECT);
  assign bus.csr_mepc_o          = mepc_q;
  assign bus.csr_mcause_o        = mcause_q;
  assign bus.csr_mtval_o         = mtval_q;
  assign bus.pc_redirect_o       = target_q;

`ifdef TRAP_SEQ_CNT_EN
  logic [CNT_WIDTH-1:0] trap_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                trap_cnt_q <= '0;
    else if (state_q == CSR_WR) trap_cnt_q <= trap_cnt_q + CNT_WIDTH'(1);
  end

  assign bus.trap_count_o = trap_cnt_q;
`else
  assign bus.trap_count_o = CNT_WIDTH'(0);
`endif

endmodule
